// File: rtl/decode_pkg.sv
// Shared definitions for the ID stage: opcodes, instruction field positions,
// the decoded control bundle and the ID/EX register layout.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_RT   = 2'd1,
    DEST_RD   = 2'd2
  } dest_sel_e;

  typedef struct packed {
    logic      regwrite;
    logic      memread;
    logic      memwrite;
    logic      branch;
    logic      illegal;
    logic      sign_ext;
    logic      use_rs;
    logic      use_rt;
    dest_sel_e dest_sel;
  } id_ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        illegal;
    logic [5:0]  funct;
  } idex_t;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sext);
    return sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Opcode to control-bundle decoder. R-type and unknown opcodes leave sign_ext
// clear, so their (unused) immediate field is zero-extended.
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [5:0] i_opcode,
  output id_ctrl_t   o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.use_rs   = 1'b1;
        o_ctrl.use_rt   = 1'b1;
        o_ctrl.dest_sel = DEST_RD;
      end
      OP_ADDI: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.sign_ext = 1'b1;
        o_ctrl.use_rs   = 1'b1;
        o_ctrl.dest_sel = DEST_RT;
      end
      OP_ANDI, OP_ORI: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.use_rs   = 1'b1;
        o_ctrl.dest_sel = DEST_RT;
      end
      OP_LW: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memread  = 1'b1;
        o_ctrl.sign_ext = 1'b1;
        o_ctrl.use_rs   = 1'b1;
        o_ctrl.dest_sel = DEST_RT;
      end
      OP_SW: begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.sign_ext = 1'b1;
        o_ctrl.use_rs   = 1'b1;
        o_ctrl.use_rt   = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.branch   = 1'b1;
        o_ctrl.sign_ext = 1'b1;
        o_ctrl.use_rs   = 1'b1;
        o_ctrl.use_rt   = 1'b1;
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decode, operand select, load-use stall and the ID/EX register.
// Define DECODE_BYPASS_EN to forward writeback data; otherwise a matching writeback stalls one cycle.
module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [4:0]  readAddr1,
  output logic [4:0]  readAddr2,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  input  logic        out_ready,
  output logic        ex_valid,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dest,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_branch,
  output logic        ex_illegal,
  output logic [5:0]  ex_funct
);

  id_ctrl_t    w_ctrl;
  idex_t       r_idex;
  idex_t       w_dec;
  logic [4:0]  w_rs, w_rt, w_rd, w_dest;
  logic [31:0] w_op1, w_op2;
  logic        w_byp1, w_byp2, w_wb_hz, w_lu_hz, w_hazard, w_hold;

  decode_ctrl u_ctrl (
    .i_opcode (in_instr[OPC_HI:OPC_LO]),
    .o_ctrl   (w_ctrl)
  );

  assign w_rs      = in_instr[RS_HI:RS_LO];
  assign w_rt      = in_instr[RT_HI:RT_LO];
  assign w_rd      = in_instr[RD_HI:RD_LO];
  assign readAddr1 = w_rs;
  assign readAddr2 = w_rt;

`ifdef DECODE_BYPASS_EN
  assign w_byp1  = wb_en && (wb_addr == w_rs);
  assign w_byp2  = wb_en && (wb_addr == w_rt);
  assign w_wb_hz = 1'b0;
`else
  // Without forwarding, wait one cycle for the register file to absorb the write.
  assign w_byp1  = 1'b0;
  assign w_byp2  = 1'b0;
  assign w_wb_hz = wb_en && (wb_addr != 5'd0) &&
                   ((w_ctrl.use_rs && (wb_addr == w_rs)) ||
                    (w_ctrl.use_rt && (wb_addr == w_rt)));
`endif

  // $0 wins over any bypass so a writeback to $0 can never leak through.
  assign w_op1 = (w_rs == 5'd0) ? 32'h0 : (w_byp1 ? wb_data : readData1);
  assign w_op2 = (w_rt == 5'd0) ? 32'h0 : (w_byp2 ? wb_data : readData2);

  always_comb begin
    case (w_ctrl.dest_sel)
      DEST_RT: w_dest = w_rt;
      DEST_RD: w_dest = w_rd;
      default: w_dest = 5'd0;
    endcase
  end

  always_comb begin
    w_dec          = '0;
    w_dec.valid    = 1'b1;
    w_dec.op1      = w_op1;
    w_dec.op2      = w_op2;
    w_dec.imm      = ext_imm(in_instr[IMM_HI:IMM_LO], w_ctrl.sign_ext);
    w_dec.dest     = w_dest;
    w_dec.regwrite = w_ctrl.regwrite && (w_dest != 5'd0);
    w_dec.memread  = w_ctrl.memread;
    w_dec.memwrite = w_ctrl.memwrite;
    w_dec.branch   = w_ctrl.branch;
    w_dec.illegal  = w_ctrl.illegal;
    w_dec.funct    = in_instr[FUNCT_HI:FUNCT_LO];
  end

  // Hazard terms ignore in_valid so in_ready never depends on in_valid.
  assign w_lu_hz  = r_idex.valid && r_idex.memread && (r_idex.dest != 5'd0) &&
                    ((w_ctrl.use_rs && (r_idex.dest == w_rs)) ||
                     (w_ctrl.use_rt && (r_idex.dest == w_rt)));
  assign w_hazard = w_lu_hz || w_wb_hz;
  assign w_hold   = !out_ready && r_idex.valid;
  assign in_ready = reset && (flush || !(w_hold || w_hazard));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    r_idex <= '0;
    else if (flush)                r_idex <= '0;
    else if (w_hold)               r_idex <= r_idex;
    else if (w_hazard | !in_valid) r_idex <= '0;
    else                           r_idex <= w_dec;
  end

  assign ex_valid    = r_idex.valid;
  assign ex_op1      = r_idex.op1;
  assign ex_op2      = r_idex.op2;
  assign ex_imm      = r_idex.imm;
  assign ex_dest     = r_idex.dest;
  assign ex_regwrite = r_idex.regwrite;
  assign ex_memread  = r_idex.memread;
  assign ex_memwrite = r_idex.memwrite;
  assign ex_branch   = r_idex.branch;
  assign ex_illegal  = r_idex.illegal;
  assign ex_funct    = r_idex.funct;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios then randomized
// traffic against a behavioural model of the ID/EX contents.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic [4:0]  readAddr1, readAddr2;
  logic [31:0] readData1 = '0, readData2 = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        ex_valid;
  logic [31:0] ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_dest;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal;
  logic [5:0]  ex_funct;

  decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(readData1), .readData2(readData2), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .out_ready(out_ready),
    .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_illegal(ex_illegal),
    .ex_funct(ex_funct)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit        v;
    bit [31:0] op1, op2, imm;
    bit [4:0]  dest;
    bit        rw, mr, mw, br, il;
    bit [5:0]  funct;
  } ex_t;

  ex_t m, nxt;
  bit  exp_rdy;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, ex_valid, m.v);
    chk({tag, ".op1"}, ex_op1, m.op1);
    chk({tag, ".op2"}, ex_op2, m.op2);
    chk({tag, ".imm"}, ex_imm, m.imm);
    chk({tag, ".dest"}, ex_dest, m.dest);
    chk({tag, ".regwrite"}, ex_regwrite, m.rw);
    chk({tag, ".memread"}, ex_memread, m.mr);
    chk({tag, ".memwrite"}, ex_memwrite, m.mw);
    chk({tag, ".branch"}, ex_branch, m.br);
    chk({tag, ".illegal"}, ex_illegal, m.il);
    chk({tag, ".funct"}, ex_funct, m.funct);
  endtask

  function automatic bit [31:0] opval(input bit [4:0] a, input bit [31:0] rd);
    if (a == 0) return 32'h0;
`ifdef DECODE_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return rd;
  endfunction

  // Expected in_ready and next ID/EX contents from the current inputs and model.
  task automatic predict();
    bit [5:0] opc;
    bit [4:0] rs, rt, rd;
    bit urs, urt, sx, lu, wbh;
    ex_t d;
    opc = in_instr[31:26]; rs = in_instr[25:21]; rt = in_instr[20:16]; rd = in_instr[15:11];
    d = '0; urs = 0; urt = 0; sx = 0;
    case (opc)
      6'h00: begin d.dest = rd; d.rw = 1; urs = 1; urt = 1; end
      6'h08: begin d.dest = rt; d.rw = 1; urs = 1; sx = 1; end
      6'h0C, 6'h0D: begin d.dest = rt; d.rw = 1; urs = 1; end
      6'h23: begin d.dest = rt; d.rw = 1; d.mr = 1; urs = 1; sx = 1; end
      6'h2B: begin d.mw = 1; urs = 1; urt = 1; sx = 1; end
      6'h04: begin d.br = 1; urs = 1; urt = 1; sx = 1; end
      default: d.il = 1;
    endcase
    if (d.dest == 0) d.rw = 0;
    d.v = 1;
    d.op1 = opval(rs, readData1);
    d.op2 = opval(rt, readData2);
    d.imm = sx ? {{16{in_instr[15]}}, in_instr[15:0]} : {16'h0, in_instr[15:0]};
    d.funct = in_instr[5:0];
    lu = m.v && m.mr && m.dest != 0 && ((urs && m.dest == rs) || (urt && m.dest == rt));
`ifdef DECODE_BYPASS_EN
    wbh = 0;
`else
    wbh = wb_en && wb_addr != 0 && ((urs && wb_addr == rs) || (urt && wb_addr == rt));
`endif
    if (flush)                  begin nxt = '0; exp_rdy = 1; end
    else if (!out_ready && m.v) begin nxt = m;  exp_rdy = 0; end
    else if (lu || wbh)         begin nxt = '0; exp_rdy = 0; end
    else                        begin nxt = in_valid ? d : '0; exp_rdy = 1; end
  endtask

  task automatic drive(input bit v, input bit [31:0] ins, input bit [31:0] r1, input bit [31:0] r2,
                       input bit we, input bit [4:0] wa, input bit [31:0] wd,
                       input bit fl, input bit ordy);
    in_valid = v; in_instr = ins; readData1 = r1; readData2 = r2;
    wb_en = we; wb_addr = wa; wb_data = wd; flush = fl; out_ready = ordy;
  endtask

  // Called away from the clock edge; checks combinational outputs, then one edge.
  task automatic cycle(input string tag);
    #1;
    predict();
    chk({tag, ".in_ready"}, in_ready, exp_rdy);
    chk({tag, ".readAddr1"}, readAddr1, in_instr[25:21]);
    chk({tag, ".readAddr2"}, readAddr2, in_instr[20:16]);
    @(posedge clk);
    #1;
    m = nxt;
    check_outs(tag);
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b0;
    #1;
    m = '0;
    check_outs(tag);
    chk({tag, ".in_ready"}, in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  localparam bit [5:0] OPS [8] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h3F};

  initial begin
    m = '0;
    @(posedge clk);
    #1;
    check_outs("reset");
    chk("reset.in_ready", in_ready, 1'b0);
    reset = 1'b1;

    // ADDI $8,$0,-1 with a non-zero readData1: op1 must still be 0.
    drive(1, 32'h2008FFFF, 32'd5, 32'd7, 0, 0, 0, 0, 1);
    cycle("addi");
    chk("addi.imm_const", ex_imm, 32'hFFFFFFFF);
    chk("addi.dest_const", ex_dest, 5'd8);
    chk("addi.rw_const", ex_regwrite, 1'b1);
    chk("addi.op1_const", ex_op1, 32'h0);

    // LW $9,0($1) then ADD $10,$9,$2: one stall cycle, then ADD enters.
    drive(1, 32'h8C290000, 32'd100, 32'd0, 0, 0, 0, 0, 1);
    cycle("lw");
    drive(1, 32'h01225020, 32'd11, 32'd22, 0, 0, 0, 0, 1);
    #1;
    chk("lu.in_ready_const", in_ready, 1'b0);
    cycle("lu_stall");
    chk("lu.bubble_const", ex_valid, 1'b0);
    cycle("lu_go");
    chk("lu.valid_const", ex_valid, 1'b1);
    chk("lu.dest_const", ex_dest, 5'd10);

    // ADDI $4,$3,16 while $3 is being written back.
    drive(1, 32'h20640010, 32'h0, 32'h0, 1, 5'd3, 32'h1234, 0, 1);
    cycle("byp");
`ifdef DECODE_BYPASS_EN
    chk("byp.op1_const", ex_op1, 32'h1234);
`else
    chk("byp.bubble_const", ex_valid, 1'b0);
    drive(1, 32'h20640010, 32'h1234, 32'h0, 0, 0, 0, 0, 1);
    cycle("byp2");
    chk("byp2.op1_const", ex_op1, 32'h1234);
`endif

    // Writeback to $0 never bypasses.
    drive(1, 32'h00000020, 32'h55, 32'h66, 1, 5'd0, 32'hDEAD, 0, 1);
    cycle("wb0");
    chk("wb0.op1_const", ex_op1, 32'h0);

    // Flush during a load-use hazard: no stall, incoming dropped.
    drive(1, 32'h8C290000, 32'd4, 32'd0, 0, 0, 0, 0, 1);
    cycle("fl_lw");
    drive(1, 32'h01225020, 32'd1, 32'd2, 0, 0, 0, 1, 1);
    #1;
    chk("flush.in_ready_const", in_ready, 1'b1);
    cycle("flush");
    chk("flush.valid_const", ex_valid, 1'b0);
    drive(1, 32'h01225020, 32'd1, 32'd2, 0, 0, 0, 0, 1);
    cycle("fl_after");

    // Downstream hold for 3 cycles, then resume.
    drive(1, 32'h34A500FF, 32'h77, 32'h0, 0, 0, 0, 0, 1);
    cycle("ori");
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'hAC850008, 32'h10, 32'h20, 0, 0, 0, 0, 0);
      cycle("hold");
      chk("hold.dest_const", ex_dest, 5'd5);
    end
    drive(1, 32'hAC850008, 32'h10, 32'h20, 0, 0, 0, 0, 1);
    cycle("resume");
    chk("resume.memwrite_const", ex_memwrite, 1'b1);

    // Randomized traffic with a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      bit [31:0] ins;
      if (i == 200) begin
        drive(1, 32'h8C220000, 32'h1, 32'h2, 0, 0, 0, 0, 0);
        cycle("pre_rst");
        async_reset("mid_rst");
      end
      ins = {OPS[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 11'($urandom)};
      drive($urandom_range(0, 99) < 85, ins, $urandom, $urandom,
            $urandom_range(0, 99) < 30, 5'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 80);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
